// File: rtl/snake_pkg.sv
// Shared match-level types for the networked snake design.
package snake_pkg;

    typedef enum logic [1:0] {
        MENU,
        LOBBY,
        GAME,
        OVER
    } game_mode;

endpackage

// File: rtl/game_tick_ctrl.sv
// GAME-phase sequencer: start countdown, then lockstep-gated board advance
// pulses with a link timeout and peer overrun detection.
module game_tick_ctrl #(
    parameter int unsigned SECOND_CYCLES  = 75_000_000,
    parameter int unsigned STEP_CYCLES    = 7_500_000,
    parameter int unsigned TIMEOUT_CYCLES = 75_000_000,
    parameter int unsigned COUNT_FROM     = 3
) (
    input  logic                clk_75,
    input  logic                rst_n,
    input  snake_pkg::game_mode mode,
    output logic                step_tx_req,
    input  logic                step_tx_ack,
    input  logic                remote_step,
    output logic                step,
    output logic [1:0]          countdown,
    output logic                running,
    output logic [15:0]         step_cnt,
    output logic                con_error
);

    localparam int unsigned TICK_MAX = (SECOND_CYCLES > STEP_CYCLES) ? SECOND_CYCLES : STEP_CYCLES;
    localparam int unsigned TW       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam int unsigned OW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [TW-1:0] SEC_LAST  = TW'(SECOND_CYCLES - 1);
    localparam logic [TW-1:0] STEP_LAST = TW'(STEP_CYCLES - 1);
    localparam logic [OW-1:0] TMO_LAST  = OW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]    CD_START  = 2'(COUNT_FROM);

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        WAIT_TICK,
        SEND,
        SYNC,
        STEP,
        ERR
    } state_t;

    state_t        state, state_d;
    logic [TW-1:0] timer, timer_d;
    logic [OW-1:0] tmo, tmo_d;
    logic          remote_seen, seen_d;
    logic          req_d, step_d, running_d, err_d;
    logic [1:0]    countdown_d;
    logic [15:0]   step_cnt_d;
    logic          in_game, overrun, fail;

    always_ff @(posedge clk_75 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            timer       <= '0;
            tmo         <= '0;
            remote_seen <= 1'b0;
            step_tx_req <= 1'b0;
            step        <= 1'b0;
            countdown   <= '0;
            running     <= 1'b0;
            step_cnt    <= '0;
            con_error   <= 1'b0;
        end else begin
            state       <= state_d;
            timer       <= timer_d;
            tmo         <= tmo_d;
            remote_seen <= seen_d;
            step_tx_req <= req_d;
            step        <= step_d;
            countdown   <= countdown_d;
            running     <= running_d;
            step_cnt    <= step_cnt_d;
            con_error   <= err_d;
        end
    end

    always_comb begin
        state_d     = state;
        timer_d     = timer;
        tmo_d       = tmo;
        seen_d      = remote_seen;
        req_d       = step_tx_req;
        step_d      = 1'b0;
        countdown_d = countdown;
        running_d   = running;
        step_cnt_d  = step_cnt;
        err_d       = con_error;
        fail        = 1'b0;
        in_game     = (mode == snake_pkg::GAME);
        overrun     = remote_step && remote_seen;

        case (state)
            IDLE: begin
                timer_d     = '0;
                tmo_d       = '0;
                seen_d      = 1'b0;
                req_d       = 1'b0;
                countdown_d = '0;
                running_d   = 1'b0;
                step_cnt_d  = '0;
                err_d       = 1'b0;
                if (in_game) begin
                    state_d     = COUNT;
                    countdown_d = CD_START;
                end
            end
            COUNT: begin
                if (timer == SEC_LAST) begin
                    timer_d = '0;
                    if (countdown == 2'd1) begin
                        countdown_d = '0;
                        running_d   = 1'b1;
                        state_d     = WAIT_TICK;
                    end else begin
                        countdown_d = countdown - 2'd1;
                    end
                end else begin
                    timer_d = timer + 1'b1;
                end
            end
            WAIT_TICK: begin
                seen_d = remote_seen | remote_step;
                if (overrun) begin
                    fail = 1'b1;
                end else if (timer == STEP_LAST) begin
                    timer_d = '0;
                    tmo_d   = '0;
                    req_d   = 1'b1;
                    state_d = SEND;
                end else begin
                    timer_d = timer + 1'b1;
                end
            end
            SEND: begin
                seen_d = remote_seen | remote_step;
                tmo_d  = tmo + 1'b1;
                if (overrun || tmo == TMO_LAST) begin
                    fail = 1'b1;
                end else if (step_tx_ack) begin
                    req_d   = 1'b0;
                    state_d = SYNC;
                end
            end
            SYNC: begin
                seen_d = remote_seen | remote_step;
                tmo_d  = tmo + 1'b1;
                if (overrun || tmo == TMO_LAST) begin
                    fail = 1'b1;
                end else if (remote_seen || remote_step) begin
                    // step and the new count are registered here so both are visible during STEP
                    seen_d     = 1'b0;
                    step_d     = 1'b1;
                    step_cnt_d = step_cnt + 16'd1;
                    state_d    = STEP;
                end
            end
            STEP: begin
                seen_d  = 1'b0;
                timer_d = '0;
                state_d = WAIT_TICK;
            end
            ERR: begin
            end
            default: state_d = IDLE;
        endcase

        if (fail) begin
            state_d   = ERR;
            err_d     = 1'b1;
            req_d     = 1'b0;
            running_d = 1'b0;
            step_d    = 1'b0;
        end

        if (!in_game && state != IDLE) begin
            state_d     = IDLE;
            timer_d     = '0;
            tmo_d       = '0;
            seen_d      = 1'b0;
            req_d       = 1'b0;
            step_d      = 1'b0;
            countdown_d = '0;
            running_d   = 1'b0;
            step_cnt_d  = '0;
            err_d       = 1'b0;
        end
    end

endmodule

// File: tb/tb_game_tick_ctrl.sv
// Randomized bench for game_tick_ctrl; expectations come from event-time
// arithmetic on the handshake rules rather than a state-by-state model.
module tb_game_tick_ctrl;
    import snake_pkg::*;

    localparam int SEC = 10;
    localparam int STP = 4;
    localparam int TMO = 20;
    localparam int CF  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    game_mode    mode;
    logic        step_tx_req;
    logic        step_tx_ack;
    logic        remote_step;
    logic        step;
    logic [1:0]  countdown;
    logic        running;
    logic [15:0] step_cnt;
    logic        con_error;

    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          next_r = 0;
    logic [15:0] model_cnt = '0;

    game_tick_ctrl #(
        .SECOND_CYCLES (SEC),
        .STEP_CYCLES   (STP),
        .TIMEOUT_CYCLES(TMO),
        .COUNT_FROM    (CF)
    ) dut (
        .clk_75     (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .step_tx_req(step_tx_req),
        .step_tx_ack(step_tx_ack),
        .remote_step(remote_step),
        .step       (step),
        .countdown  (countdown),
        .running    (running),
        .step_cnt   (step_cnt),
        .con_error  (con_error)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_all(input logic e_req, input logic e_step, input logic [1:0] e_cd,
                             input logic e_run, input logic [15:0] e_cnt, input logic e_err);
        check("step_tx_req", 32'(step_tx_req), 32'(e_req));
        check("step", 32'(step), 32'(e_step));
        check("countdown", 32'(countdown), 32'(e_cd));
        check("running", 32'(running), 32'(e_run));
        check("step_cnt", 32'(step_cnt), 32'(e_cnt));
        check("con_error", 32'(con_error), 32'(e_err));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic junk();
        return ($urandom_range(0, 3) == 0);
    endfunction

    // Countdown from mode entry; remote/ack pulses here must be ignored.
    task automatic start_game();
        int c0 = cyc;
        mode = GAME;
        for (int rel = 1; rel <= CF * SEC; rel++) begin
            remote_step = junk();
            step_tx_ack = junk();
            tick();
            check_all(1'b0, 1'b0, 2'(CF - (rel - 1) / SEC), 1'b0, 16'd0, 1'b0);
        end
        remote_step = 1'b0;
        step_tx_ack = 1'b0;
        model_cnt   = '0;
        next_r      = c0 + CF * SEC + STP + 1;
    endtask

    // One lockstep round. Request rises at edge r; ack is sampled at edge r+da+1;
    // remote is sampled at edge r+k. Step lands at r+max(da+2,k) unless that
    // reaches the timeout edge r+TMO first.
    task automatic run_round(input int da, input int k, input bit acked, output bit timed_out);
        int r     = next_r;
        int s_rel = (da + 2 > k) ? da + 2 : k;
        int s     = r + s_rel;
        int t_err = r + TMO;
        int last;
        logic e_req, e_step, e_err;
        timed_out = !acked || (s_rel >= TMO);
        last = timed_out ? t_err : s;
        while (cyc < last) begin
            int e = cyc + 1;
            remote_step = (e == r + k);
            step_tx_ack = acked && (e == r + da + 1);
            if (e <= r || (acked && e > r + da + 1))
                step_tx_ack = junk();
            tick();
            e_req  = (cyc >= r) && (cyc < t_err) && (!acked || cyc <= r + da);
            e_step = !timed_out && (cyc == s);
            e_err  = timed_out && (cyc >= t_err);
            if (e_step) model_cnt++;
            check_all(e_req, e_step, 2'd0, !e_err, model_cnt, e_err);
        end
        remote_step = 1'b0;
        step_tx_ack = 1'b0;
        if (!timed_out) next_r = s + STP + 1;
    endtask

    task automatic hold_error(input int n);
        for (int i = 0; i < n; i++) begin
            remote_step = junk();
            step_tx_ack = junk();
            tick();
            check_all(1'b0, 1'b0, 2'd0, 1'b0, model_cnt, 1'b1);
        end
        remote_step = 1'b0;
        step_tx_ack = 1'b0;
    endtask

    task automatic exit_mode();
        mode = MENU;
        model_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            remote_step = junk();
            step_tx_ack = junk();
            tick();
            check_all(1'b0, 1'b0, 2'd0, 1'b0, 16'd0, 1'b0);
        end
        remote_step = 1'b0;
        step_tx_ack = 1'b0;
    endtask

    task automatic leave_in_send();
        int r = next_r;
        while (cyc < r + 1) begin
            tick();
            check_all(cyc >= r, 1'b0, 2'd0, 1'b1, model_cnt, 1'b0);
        end
        mode = MENU;
        tick();
        model_cnt = '0;
        check_all(1'b0, 1'b0, 2'd0, 1'b0, 16'd0, 1'b0);
    endtask

    task automatic overrun_in_wait();
        int r = next_r;
        while (cyc < r - 1) begin
            int e = cyc + 1;
            remote_step = (e == r - 3) || (e == r - 1);
            tick();
            check_all(1'b0, 1'b0, 2'd0, cyc < r - 1, model_cnt, cyc >= r - 1);
        end
        remote_step = 1'b0;
    endtask

    task automatic reset_in_sync();
        int r = next_r;
        while (cyc < r + 1) begin
            step_tx_ack = (cyc + 1 == r + 1);
            tick();
            check_all(cyc == r, 1'b0, 2'd0, 1'b1, model_cnt, 1'b0);
        end
        step_tx_ack = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all(1'b0, 1'b0, 2'd0, 1'b0, 16'd0, 1'b0);
        mode = MENU;
        model_cnt = '0;
        tick();
        check_all(1'b0, 1'b0, 2'd0, 1'b0, 16'd0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_all(1'b0, 1'b0, 2'd0, 1'b0, 16'd0, 1'b0);
    endtask

    initial begin
        bit to;
        rst_n       = 1'b1;
        mode        = MENU;
        step_tx_ack = 1'b0;
        remote_step = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all(1'b0, 1'b0, 2'd0, 1'b0, 16'd0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_all(1'b0, 1'b0, 2'd0, 1'b0, 16'd0, 1'b0);

        // Fixed handshake: ack 2 after request, remote 3 after ack.
        start_game();
        for (int i = 0; i < 5; i++) run_round(2, 6, 1'b1, to);
        check("step_cnt_after_5", 32'(step_cnt), 32'd5);
        // Peer one step ahead: remote during WAIT_TICK.
        run_round(1, -2, 1'b1, to);
        // Latest remote that still beats the timeout.
        run_round(0, TMO - 1, 1'b1, to);
        for (int i = 0; i < 20; i++) begin
            int da = int'($urandom_range(0, 5));
            int k  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, STP - 1)) - (STP - 1)
                                                 : int'($urandom_range(1, 12));
            run_round(da, k, 1'b1, to);
        end

        leave_in_send();
        tick();
        check_all(1'b0, 1'b0, 2'd0, 1'b0, 16'd0, 1'b0);

        // Never acked: timeout, sticky error, cleared by mode exit.
        start_game();
        run_round(1, 5, 1'b1, to);
        run_round(0, 99, 1'b0, to);
        check("timeout_flag", 32'(to), 32'd1);
        hold_error(12);
        exit_mode();

        // Two remote pulses without an intervening step.
        start_game();
        run_round(2, 3, 1'b1, to);
        overrun_in_wait();
        hold_error(8);
        exit_mode();

        // Counter wrap, then ack accepted but sync landing on the timeout edge.
        start_game();
        run_round(0, 2, 1'b1, to);
        force dut.step_cnt_d = 16'hFFFE;
        tick();
        release dut.step_cnt_d;
        model_cnt = 16'hFFFE;
        check_all(1'b0, 1'b0, 2'd0, 1'b1, 16'hFFFE, 1'b0);
        run_round(1, 4, 1'b1, to);
        run_round(3, -1, 1'b1, to);
        check("step_cnt_wrapped", 32'(step_cnt), 32'd0);
        run_round(TMO - 2, 1, 1'b1, to);
        check("late_ack_timeout", 32'(to), 32'd1);
        hold_error(5);
        exit_mode();

        // Asynchronous reset while waiting for the peer.
        start_game();
        run_round(1, 3, 1'b1, to);
        run_round(0, -3, 1'b1, to);
        reset_in_sync();
        start_game();
        run_round(2, 2, 1'b1, to);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
